// File: rtl/lmsm_sequencer_if.sv
// Bundle between decode/memory stage and the LM/SM sequencer.
// Micro-op handshake: a micro-op is transferred on a rising edge where op_valid=1 and stall_in=0;
// while stall_in=1 the sequencer holds op_reg/op_addr/op_is_load/pc_write unchanged.
interface lmsm_sequencer_if;
    logic        start;
    logic        is_lm;
    logic [15:0] base_addr;
    logic [7:0]  reg_mask;
    logic        stall_in;
    logic        flush;
    logic        busy;
    logic        op_valid;
    logic        op_is_load;
    logic [2:0]  op_reg;
    logic [15:0] op_addr;
    logic        pc_write;
    logic        done;

    modport master (
        output start, is_lm, base_addr, reg_mask, stall_in, flush,
        input  busy, op_valid, op_is_load, op_reg, op_addr, pc_write, done
    );

    modport slave (
        input  start, is_lm, base_addr, reg_mask, stall_in, flush,
        output busy, op_valid, op_is_load, op_reg, op_addr, pc_write, done
    );
endinterface

// File: rtl/lmsm_sequencer.sv
// Load/store-multiple sequencer: expands one LM/SM instruction into one micro-op per set
// mask bit, lowest register first, with consecutive word addresses from the base.
module lmsm_sequencer (
    input  logic              clk,
    input  logic              reset,
    lmsm_sequencer_if.slave   bus,
    output logic [1:0]        dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  mask_q, mask_d;
    logic [15:0] addr_q, addr_d;
    logic        is_lm_q, is_lm_d;
    logic [2:0]  low_idx;
    logic [7:0]  low_bit;
    logic        in_run;

    // Descending scan so the last hit is the lowest set bit.
    always_comb begin
        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i]) low_idx = 3'(i);
        end
    end

    assign low_bit = 8'd1 << low_idx;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        is_lm_d = is_lm_q;
        case (state_q)
            IDLE: begin
                if (!bus.flush && bus.start) begin
                    is_lm_d = bus.is_lm;
                    addr_d  = bus.base_addr;
                    mask_d  = bus.reg_mask;
                    state_d = (bus.reg_mask != 8'd0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (bus.flush) begin
                    mask_d  = 8'd0;
                    state_d = IDLE;
                end else if (!bus.stall_in) begin
                    mask_d = mask_q & ~low_bit;
                    addr_d = addr_q + 16'd1;
                    if ((mask_q & ~low_bit) == 8'd0) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= 8'd0;
            addr_q  <= 16'h0000;
            is_lm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            is_lm_q <= is_lm_d;
        end
    end

    // Outputs depend only on registered state, so stall/flush never reach them combinationally.
    assign in_run         = (state_q == RUN);
    assign bus.busy       = in_run;
    assign bus.op_valid   = in_run;
    assign bus.op_reg     = in_run ? low_idx : 3'd0;
    assign bus.op_addr    = in_run ? addr_q : 16'h0000;
    assign bus.op_is_load = in_run & is_lm_q;
    assign bus.pc_write   = in_run & is_lm_q & (low_idx == 3'd7);
    assign bus.done       = (state_q == DONE);
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed and randomized checks of lmsm_sequencer against a queue-based model of the
// expected micro-op stream.
module tb_lmsm_sequencer;
    logic       clk;
    logic       reset;
    logic [1:0] dbg_state;
    int         tests_run;
    int         failures;
    int         busy_seen;

    // Model: pending micro-ops as {reg, addr}, plus whether a done pulse is due.
    logic [18:0] exp_q[$];
    logic        m_lm;
    logic        m_done;

    lmsm_sequencer_if bus ();

    lmsm_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string pfx);
        logic        v;
        logic [18:0] f;
        v = (exp_q.size() != 0);
        f = v ? exp_q[0] : 19'd0;
        chk({pfx, "_busy"}, 16'(bus.busy), 16'(v));
        chk({pfx, "_op_valid"}, 16'(bus.op_valid), 16'(v));
        chk({pfx, "_op_is_load"}, 16'(bus.op_is_load), 16'(v && m_lm));
        chk({pfx, "_pc_write"}, 16'(bus.pc_write), 16'(v && m_lm && f[18:16] == 3'd7));
        chk({pfx, "_done"}, 16'(bus.done), 16'(m_done));
        if (v) begin
            chk({pfx, "_op_reg"}, 16'(bus.op_reg), 16'(f[18:16]));
            chk({pfx, "_op_addr"}, bus.op_addr, f[15:0]);
        end
    endtask

    // Driver: present inputs for one cycle, advance the model by the same edge, then check.
    task automatic tick(input logic st, input logic lm, input logic [15:0] base,
                        input logic [7:0] mask, input logic stall, input logic fl);
        int n;
        bus.start     = st;
        bus.is_lm     = lm;
        bus.base_addr = base;
        bus.reg_mask  = mask;
        bus.stall_in  = stall;
        bus.flush     = fl;
        if (fl) begin
            exp_q.delete();
            m_done = 1'b0;
        end else if (exp_q.size() != 0) begin
            if (!stall) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) m_done = 1'b1;
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (st) begin
            m_lm = lm;
            n = 0;
            for (int i = 0; i < 8; i++) begin
                if (mask[i]) begin
                    exp_q.push_back({3'(i), base + 16'(n)});
                    n++;
                end
            end
            if (n == 0) m_done = 1'b1;
        end
        @(posedge clk);
        #1;
        check_outputs("cyc");
        if (bus.busy) busy_seen++;
    endtask

    task automatic idle_tick();
        tick(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);
    endtask

    // Run until the model has nothing pending; noise adds random starts and flushes.
    task automatic drain(input int stall_pct, input bit noise);
        int k;
        for (k = 0; k < 80 && (exp_q.size() != 0 || m_done); k++) begin
            tick(noise ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 1)),
                 16'($urandom), 8'($urandom),
                 ($urandom_range(0, 99) < stall_pct) ? 1'b1 : 1'b0,
                 (noise && $urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
        end
        chk("drain_bound", 16'(exp_q.size() != 0 || m_done), 16'd0);
    endtask

    // Asynchronous reset between edges; outputs must clear before the next edge.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        exp_q.delete();
        m_done = 1'b0;
        m_lm   = 1'b0;
        #1;
        check_outputs("rst");
        chk("rst_op_reg", 16'(bus.op_reg), 16'd0);
        chk("rst_op_addr", bus.op_addr, 16'h0000);
        @(posedge clk);
        #1;
        check_outputs("rst_hold");
        reset = 1'b0;
    endtask

    initial begin
        tests_run = 0;
        failures  = 0;
        busy_seen = 0;
        m_lm      = 1'b0;
        m_done    = 1'b0;
        reset     = 1'b0;
        bus.start = 1'b0; bus.is_lm = 1'b0; bus.base_addr = 16'h0; bus.reg_mask = 8'h0;
        bus.stall_in = 1'b0; bus.flush = 1'b0;

        // Power-up reset, released so the next edge can sample a start.
        #1 reset = 1'b1;
        #2;
        check_outputs("init");
        chk("init_op_reg", 16'(bus.op_reg), 16'd0);
        chk("init_op_addr", bus.op_addr, 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // LM A5 from 0100, no stall: four ops, busy for exactly four cycles.
        busy_seen = 0;
        tick(1'b1, 1'b1, 16'h0100, 8'b1010_0101, 1'b0, 1'b0);
        drain(0, 1'b0);
        chk("lm_a5_busy_cycles", 16'(busy_seen), 16'd4);

        // SM 06 from 0040 with three stall cycles on the first op.
        tick(1'b1, 1'b0, 16'h0040, 8'b0000_0110, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
        drain(0, 1'b0);

        // Empty mask: no ops, a single done pulse.
        busy_seen = 0;
        tick(1'b1, 1'b1, 16'h1234, 8'h00, 1'b0, 1'b0);
        idle_tick();
        idle_tick();
        chk("empty_mask_busy_cycles", 16'(busy_seen), 16'd0);

        // SM FF from FFFE wraps through 0000; starts during RUN are ignored.
        tick(1'b1, 1'b0, 16'hFFFE, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 16'h5555, 8'h0F, 1'b0, 1'b0);
        drain(0, 1'b0);
        idle_tick();

        // LM F0 flushed on its second op, then a normal single-register LM.
        tick(1'b1, 1'b1, 16'h2000, 8'hF0, 1'b0, 1'b0);
        idle_tick();
        tick(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b1);
        idle_tick();
        idle_tick();
        tick(1'b1, 1'b1, 16'h3000, 8'h01, 1'b0, 1'b0);
        drain(0, 1'b0);

        // Flush and start together in IDLE: flush wins.
        tick(1'b1, 1'b1, 16'h4000, 8'h80, 1'b0, 1'b1);
        idle_tick();

        // Flush on the last micro-op: no done pulse.
        tick(1'b1, 1'b1, 16'h5000, 8'h80, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b1);
        idle_tick();

        // Asynchronous reset mid-RUN, then a clean start on the first edge.
        tick(1'b1, 1'b1, 16'($urandom), 8'hFF, 1'b0, 1'b0);
        idle_tick();
        idle_tick();
        async_reset();
        tick(1'b1, 1'b0, 16'h6000, 8'h81, 1'b0, 1'b0);
        drain(0, 1'b0);

        // Randomized instructions with random stalls, stray starts and flushes.
        for (int t = 0; t < 60; t++) begin
            tick(1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
                 1'($urandom_range(0, 1)), 1'b0);
            drain(30, 1'b1);
            if ($urandom_range(0, 2) == 0) idle_tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule
